// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// 32-entry general-purpose register file for the processor datapath. It has one
// synchronous write port and two combinational read ports. Register 0 has no
// storage and always reads zero. The array feeds the two 32:1 read-select muxes
// that drive the decode/execute operand buses.
//
// Parameters:
//   DATA_WIDTH    register and data-port width (default 32)
//   ADDR_WIDTH    register index width; entry count is 2**ADDR_WIDTH (default 5)
//
// Ports:
//   clock         system clock; all state updates on the rising edge
//   reset         synchronous, active-high; clears the whole array and
//                 wins over a concurrent write
//   write_enable  qualifies the write this cycle
//   write_reg     destination register index (a write to index 0 is dropped)
//   write_data    value to write
//   read_reg_a    source index, port A
//   read_reg_b    source index, port B
//   read_data_a   contents of read_reg_a (combinational)
//   read_data_b   contents of read_reg_b (combinational)
//
// Build option:
//   REGFILE_BYPASS_EN  When this macro is defined, a qualified write is
//                      forwarded combinationally to any read port that
//                      addresses the same nonzero index in the same cycle.
//                      When it is undefined, a same-cycle read returns the
//                      contents the array held before the edge. The array
//                      update is identical in both builds.
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg_a,
    input  logic [ADDR_WIDTH-1:0] read_reg_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Only entries 1..NUM_REGS-1 have storage. Register 0 is a constant.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // One-hot write select. Bit 0 is never set, so writes to r0 vanish here.
    logic [NUM_REGS-1:0] write_sel;

    // Full 0..NUM_REGS-1 view of the array that feeds both read muxes.
    logic [DATA_WIDTH-1:0] read_view [0:NUM_REGS-1];

    // -------------------------------------------------------------------------
    // Write decode and next-state array
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any condition,
        // so no path can leave it unassigned and infer a latch.
        write_sel = '0;
        if (write_enable) begin
            write_sel[write_reg] = 1'b1;
        end
        write_sel[0] = 1'b0;
    end

    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = write_sel[i] ? write_data : regs_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // Storage. Reset is sampled on the clock edge and overrides any write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this array is reset on purpose. The architecture needs every
            // register to read zero after reset. A plain RAM-style array with no
            // reset would be cheaper, but it cannot give that guarantee.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that all
            // flops sample pre-edge values no matter how the block is ordered.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: two independent 32:1 selections over the same view.
    // -------------------------------------------------------------------------
    assign read_view[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_read_view
        assign read_view[g] = regs_q[g];
    end

`ifdef REGFILE_BYPASS_EN
    // A write counts as forwardable only if it will actually land at the next
    // edge. That excludes writes made during reset and writes to r0.
    logic write_live;
    assign write_live = write_enable && !reset && (write_reg != '0);

    always_comb begin
        read_data_a = read_view[read_reg_a];
        if (write_live && (read_reg_a == write_reg)) begin
            read_data_a = write_data;
        end
    end

    always_comb begin
        read_data_b = read_view[read_reg_b];
        if (write_live && (read_reg_b == write_reg)) begin
            read_data_b = write_data;
        end
    end
`else
    assign read_data_a = read_view[read_reg_a];
    assign read_data_b = read_view[read_reg_b];
`endif

endmodule
